// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter that feeds one bit-serial
// Gray-to-binary engine from NUM_REQ requesters. Word converted MSB first,
// one bit per clock; result posted with requester ID and 1-cycle strobe.
// Optional build macro GCA_FIXED_PRIO_EN: lowest asserted index always wins
// (no rotating pointer).
module gray_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] gray_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         bin_out,
    output logic [ID_W-1:0]          bin_id,
    output logic                     bin_valid,
    output logic                     busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state, state_nx;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      cur_id;
    logic [WIDTH-1:0]     g_sh;
    logic [WIDTH-1:0]     acc, acc_nx;
    logic                 prev_b, b_bit;
    logic [CW-1:0]        cnt;
    logic [NUM_REQ-1:0]   gnt_nx;
    logic                 valid_nx;
`ifndef GCA_FIXED_PRIO_EN
    logic [ID_W-1:0]      last_id;
`endif

    // Winner selection; loop runs from lowest to highest priority so the
    // last assignment is the highest-priority asserted requester.
    always_comb begin
        winner = '0;
`ifdef GCA_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[k]) winner = ID_W'(k);
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ID_W'((int'(last_id) + k) % NUM_REQ)])
                winner = ID_W'((int'(last_id) + k) % NUM_REQ);
        end
`endif
    end

    // Serial conversion step: current binary bit from previous bit and gray bit.
    always_comb begin
        b_bit       = prev_b ^ g_sh[cnt];
        acc_nx      = acc;
        acc_nx[cnt] = b_bit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req)     state_nx = CONV;
            CONV:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: values the registered outputs take on the next edge.
    always_comb begin
        gnt_nx   = '0;
        valid_nx = 1'b0;
        if (state == IDLE && |req) gnt_nx = NUM_REQ'(1) << winner;
        if (state == CONV && cnt == '0) valid_nx = 1'b1;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= '0;
            bin_out   <= '0;
            bin_id    <= '0;
            bin_valid <= 1'b0;
            busy      <= 1'b0;
            g_sh      <= '0;
            acc       <= '0;
            prev_b    <= 1'b0;
            cnt       <= '0;
            cur_id    <= '0;
`ifndef GCA_FIXED_PRIO_EN
            last_id   <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt       <= gnt_nx;
            bin_valid <= valid_nx;
            busy      <= (state_nx != IDLE);
            case (state)
                IDLE: if (|req) begin
                    g_sh    <= gray_in[int'(winner)*WIDTH +: WIDTH];
                    acc     <= '0;
                    prev_b  <= 1'b0;
                    cnt     <= CW'(WIDTH - 1);
                    cur_id  <= winner;
`ifndef GCA_FIXED_PRIO_EN
                    last_id <= winner;
`endif
                end
                CONV: begin
                    acc    <= acc_nx;
                    prev_b <= b_bit;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bin_out <= acc_nx;
                        bin_id  <= cur_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
